// File: rtl/relm_fp_pack.sv
// relm_fp_pack: multi-cycle normalise/round/pack of an unpacked FP result into an IEEE-754 single (optional denormals via RELM_FP_PACK_DENORM_EN; ports clk, rst, in_valid/in_ready/in_hdr/in_mant, out_valid/out_ready/out_data/out_ovf/out_unf)
module relm_fp_pack #(
  parameter int WD = 32,
  parameter int NSTEP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_hdr,
  input  logic [WD-1:0] in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data,
  output logic          out_ovf,
  output logic          out_unf
);
  typedef enum logic [2:0] {IDLE, NORM, ROUND, DENORM, DONE} state_t;
  state_t state, state_n;
  logic sign, sign_n, ovf_n, unf_n, up, unused;
  logic signed [9:0] exp, exp_n, exp_r;
  logic [31:0] mant, mant_n, shr, data_n;
  logic [23:0] rnd;
  logic [4:0] cnt, cnt_n;
  assign unused = ^in_hdr[20:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign shr = {1'b0, mant[31:2], mant[1] | mant[0]};
  assign up = mant[6] & ((|mant[5:0]) | mant[7]);
  assign rnd = {1'b0, mant[29:7]} + {23'd0, up};
  assign exp_r = exp + $signed({9'd0, rnd[23]});
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_unf <= 1'b0;
      sign <= 1'b0;
      exp <= '0;
      mant <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      out_data <= data_n;
      out_ovf <= ovf_n;
      out_unf <= unf_n;
      sign <= sign_n;
      exp <= exp_n;
      mant <= mant_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    data_n = out_data;
    ovf_n = out_ovf;
    unf_n = out_unf;
    sign_n = sign;
    exp_n = exp;
    mant_n = mant;
    cnt_n = cnt;
    case (state)
      IDLE: if (in_valid) begin
        sign_n = in_hdr[31];
        exp_n = {2'b00, in_hdr[30:23]};
        mant_n = in_mant;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        state_n = (in_hdr[22] | in_hdr[21] | in_mant == '0) ? DONE : NORM;
        data_n = (in_hdr[22] & in_hdr[21]) ? {in_hdr[31], 8'hFF, 1'b1, 22'd0} :
                 in_hdr[22] ? {in_hdr[31], 8'hFF, 23'd0} : {in_hdr[31], 31'd0};
      end
      NORM: begin
        if (mant[31]) begin
          mant_n = shr;
          exp_n = exp + 10'sd1;
        end else if (mant[30]) state_n = ROUND;
        else if (mant[30:31-NSTEP] == '0) begin
          mant_n = mant << NSTEP;
          exp_n = exp - 10'(NSTEP);
        end else begin
          mant_n = mant << 1;
          exp_n = exp - 10'sd1;
        end
      end
      ROUND: begin
        state_n = DONE;
        if (exp_r >= 10'sd255) begin
          data_n = {sign, 8'hFF, 23'd0};
          ovf_n = 1'b1;
        end else if (exp_r <= 10'sd0) begin
`ifdef RELM_FP_PACK_DENORM_EN
          state_n = DENORM;
          cnt_n = '0;
`else
          data_n = {sign, 31'd0};
          unf_n = 1'b1;
`endif
        end else data_n = {sign, exp_r[7:0], rnd[22:0]};
      end
      DENORM: begin
        if (exp < 10'sd1 && cnt != 5'd26) begin
          mant_n = shr;
          exp_n = exp + 10'sd1;
          cnt_n = cnt + 5'd1;
        end else begin
          // a rounding carry lands in the exponent LSB, giving the min normal
          data_n = {sign, 7'd0, rnd};
          unf_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_relm_fp_pack.sv
module tb_relm_fp_pack;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_ovf, out_unf;
  logic [31:0] in_hdr = 0, in_mant = 0, out_data;
  int checks = 0, failures = 0;
  localparam int NSTEP = 8;
  always #5 clk = ~clk;
  relm_fp_pack #(.WD(32), .NSTEP(NSTEP)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_hdr(in_hdr), .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf));
  typedef struct {
    string nm;
    logic [31:0] hdr, mant, data;
    logic ovf, unf;
    int lat;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [23:0] rne(input logic [31:0] m);
    logic [23:0] q = 24'(m >> 7) & 24'h7FFFFF;
    int r = int'(m & 32'h7F);
    if (r > 64 || (r == 64 && q[0])) q++;
    return q;
  endfunction
  task automatic model(input logic [31:0] hdr, mant, output logic [31:0] d, output logic o, u, output int lat);
    logic s = hdr[31];
    int e = int'(hdr[30:23]), p = 0, sh;
    logic [31:0] m, mm;
    logic [23:0] q;
    o = 0; u = 0; lat = 1;
    if (hdr[22] && hdr[21]) begin d = {s, 31'h7FC00000}; return; end
    if (hdr[22]) begin d = {s, 31'h7F800000}; return; end
    if (hdr[21] || mant == 0) begin d = {s, 31'd0}; return; end
    for (int i = 0; i < 32; i++) if (mant[i]) p = i;
    if (p == 31) begin
      m = (mant >> 1) | (mant & 1); e++; lat = 4;
    end else begin
      m = mant << (30 - p); e -= 30 - p; lat = 3 + (30 - p) / NSTEP + (30 - p) % NSTEP;
    end
    q = rne(m);
    if (q[23] && e + 1 >= 255) begin o = 1; d = {s, 31'h7F800000}; end
    else if (!q[23] && e >= 255) begin o = 1; d = {s, 31'h7F800000}; end
    else if (e + int'(q[23]) >= 1) d = {s, 8'(e + int'(q[23])), q[22:0]};
    else begin
      u = 1;
`ifdef RELM_FP_PACK_DENORM_EN
      sh = (1 - e > 26) ? 26 : 1 - e;
      mm = (m >> sh) | ((m & ((32'd1 << sh) - 1)) != 0 ? 32'd1 : 32'd0);
      q = rne(mm);
      d = {s, 7'd0, q};
      lat += sh + 1;
`else
      sh = 0;
      mm = m;
      d = {s, 31'd0};
`endif
    end
  endtask
  task automatic run(input string nm, input logic [31:0] hdr, mant, d, input logic o, u, input int lat, input int hold);
    int n;
    logic [31:0] held;
    @(negedge clk); in_hdr = hdr; in_mant = mant; in_valid = 1;
    @(posedge clk); #1 in_valid = 0; n = 1;
    while (!out_valid && n < 200) begin @(posedge clk); #1 n++; end
    chk({nm, " lat"}, n, lat);
    chk({nm, " data"}, out_data, d);
    chk({nm, " ovf"}, {31'd0, out_ovf}, {31'd0, o});
    chk({nm, " unf"}, {31'd0, out_unf}, {31'd0, u});
    chk({nm, " in_ready busy"}, {31'd0, in_ready}, 0);
    held = out_data;
    repeat (hold) @(posedge clk);
    if (hold > 0) begin
      #1 chk({nm, " held data"}, out_data, held);
      chk({nm, " held valid"}, {31'd0, out_valid}, 1);
      chk({nm, " held in_ready"}, {31'd0, in_ready}, 0);
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk({nm, " in_ready after"}, {31'd0, in_ready}, 1);
  endtask
  initial begin
    logic [31:0] h, m, d;
    logic o, u;
    int lat;
    vecs[0] = '{"one", 32'h3F800000, 32'h40000000, 32'h3F800000, 0, 0, 3};
    vecs[1] = '{"carry", 32'h3F800000, 32'h80000000, 32'h40000000, 0, 0, 4};
    vecs[2] = '{"coarse", 32'h3F800000, 32'h00000080, 32'h34000000, 0, 0, 12};
    vecs[3] = '{"tie_even", 32'h3F800000, 32'h40000040, 32'h3F800000, 0, 0, 3};
    vecs[4] = '{"tie_odd", 32'h3F800000, 32'h400000C0, 32'h3F800002, 0, 0, 3};
    vecs[5] = '{"round_carry", 32'h3F800000, 32'h7FFFFFC0, 32'h40000000, 0, 0, 3};
    vecs[6] = '{"ovf", 32'h7F000000, 32'h80000000, 32'h7F800000, 1, 0, 4};
    vecs[7] = '{"nan", 32'h00600000, 32'h40000000, 32'h7FC00000, 0, 0, 1};
    vecs[8] = '{"neg_zero", 32'h80200000, 32'h12345678, 32'h80000000, 0, 0, 1};
    vecs[9] = '{"neg_inf", 32'h80400000, 32'h40000000, 32'hFF800000, 0, 0, 1};
    vecs[10] = '{"mant_zero", 32'h3F800000, 32'h00000000, 32'h00000000, 0, 0, 1};
`ifdef RELM_FP_PACK_DENORM_EN
    vecs[11] = '{"unf", 32'h00800000, 32'h20000000, 32'h00400000, 0, 1, 6};
`else
    vecs[11] = '{"unf", 32'h00800000, 32'h20000000, 32'h00000000, 0, 1, 4};
`endif
    vecs[12] = '{"neg_one", 32'hBF800000, 32'h40000000, 32'hBF800000, 0, 0, 3};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset in_ready", {31'd0, in_ready}, 1);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset out_data", out_data, 0);
    chk("reset ovf", {31'd0, out_ovf}, 0);
    chk("reset unf", {31'd0, out_unf}, 0);
    foreach (vecs[i]) run(vecs[i].nm, vecs[i].hdr, vecs[i].mant, vecs[i].data, vecs[i].ovf, vecs[i].unf, vecs[i].lat, 0);
    run("stall", 32'h3F800000, 32'h40000000, 32'h3F800000, 0, 0, 3, 3);
    @(negedge clk); in_hdr = 32'h3F800000; in_mant = 32'h00000080; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst mid valid", {31'd0, out_valid}, 0);
    chk("rst mid in_ready", {31'd0, in_ready}, 1);
    chk("rst mid data", out_data, 0);
    for (int k = 0; k < 300; k++) begin
      h = $urandom;
      h[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      h[22] = ($urandom_range(0, 15) == 0);
      h[21] = ($urandom_range(0, 15) == 0);
      m = ($urandom_range(0, 31) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) m[31] = 1'b1;
      model(h, m, d, o, u, lat);
      run("rand", h, m, d, o, u, lat, $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
